// File: rtl/cache_responder.sv
// Direct-mapped write-back cache with a four-phase request/valid handshake toward the master.
// Define CACHE_RESPONDER_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_responder #(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 32,
    parameter int LINES        = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              operation,
    input  logic [ADDRESSWIDTH-1:0] addr,
    input  logic [DATAWIDTH-1:0]    wdata,
    output logic [DATAWIDTH-1:0]    rdata,
    input  logic                    request,
    output logic                    valid,
    output logic                    evict,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDRESSWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0]    mem_wdata,
    input  logic [DATAWIDTH-1:0]    mem_rdata,
    input  logic                    mem_ack
`ifdef CACHE_RESPONDER_STATS_EN
    ,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
`endif
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = ADDRESSWIDTH - IDX;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND, RELEASE} state_t;

    state_t                  state;
    logic [1:0]              op_q;
    logic [ADDRESSWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0]    wdata_q;

    logic [LINES-1:0]        line_valid;
    logic [LINES-1:0]        line_dirty;
    logic [TW-1:0]           line_tag  [LINES];
    logic [DATAWIDTH-1:0]    line_data [LINES];

    logic [IDX-1:0]          idx;
    logic [TW-1:0]           tag;
    logic                    hit;
    logic                    victim_dirty;
    logic                    need_wb;

    assign idx          = addr_q[IDX-1:0];
    assign tag          = addr_q[ADDRESSWIDTH-1:IDX];
    assign hit          = line_valid[idx] && (line_tag[idx] == tag);
    assign victim_dirty = line_valid[idx] && line_dirty[idx];
    // Invalidate only writes back the line it hits; read/write write back whatever victim they displace.
    assign need_wb      = (op_q == OP_INVAL) ? (hit && line_dirty[idx])
                        : ((op_q != OP_NOP) && !hit && victim_dirty);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            valid      <= 1'b0;
            evict      <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            line_valid <= '0;
            line_dirty <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        op_q    <= operation;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (operation == OP_NOP) begin
                            valid <= 1'b1;
                            state <= RESPOND;
                        end else begin
                            state <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    if (need_wb) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {line_tag[idx], idx};
                        mem_wdata <= line_data[idx];
                        state     <= WRITEBACK;
                    end else if (op_q == OP_READ && !hit) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= addr_q;
                        state    <= FILL;
                    end else begin
                        case (op_q)
                            OP_READ: rdata <= line_data[idx];
                            OP_WRITE: begin
                                line_data[idx]  <= wdata_q;
                                line_tag[idx]   <= tag;
                                line_valid[idx] <= 1'b1;
                                line_dirty[idx] <= 1'b1;
                            end
                            OP_INVAL: if (hit) line_valid[idx] <= 1'b0;
                            default: ;
                        endcase
                        valid <= 1'b1;
                        state <= RESPOND;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        evict           <= 1'b1;
                        line_dirty[idx] <= 1'b0;
                        mem_we          <= 1'b0;
                        if (op_q == OP_READ) begin
                            // mem_req stays high; the fill request follows back-to-back
                            mem_addr <= addr_q;
                            state    <= FILL;
                        end else begin
                            mem_req <= 1'b0;
                            if (op_q == OP_WRITE) begin
                                line_data[idx]  <= wdata_q;
                                line_tag[idx]   <= tag;
                                line_valid[idx] <= 1'b1;
                                line_dirty[idx] <= 1'b1;
                            end else begin
                                line_valid[idx] <= 1'b0;
                            end
                            valid <= 1'b1;
                            state <= RESPOND;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req         <= 1'b0;
                        line_valid[idx] <= 1'b1;
                        line_dirty[idx] <= 1'b0;
                        line_tag[idx]   <= tag;
                        line_data[idx]  <= mem_rdata;
                        rdata           <= mem_rdata;
                        valid           <= 1'b1;
                        state           <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (!request) begin
                        valid <= 1'b0;
                        evict <= 1'b0;
                        rdata <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_RESPONDER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && (op_q == OP_READ || op_q == OP_WRITE)) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_responder.sv
// Scoreboard bench for cache_responder: directed transactions push expected responses and
// memory traffic into queues; a response monitor and a memory model pop and compare.
module tb_cache_responder;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, INV = 2'b10, NOP = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  operation;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        request;
    logic        valid;
    logic        evict;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
`ifdef CACHE_RESPONDER_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_responder dut (
        .clock(clock), .reset(reset), .operation(operation), .addr(addr), .wdata(wdata),
        .rdata(rdata), .request(request), .valid(valid), .evict(evict),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_RESPONDER_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] rd;
        logic       ev;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [7:0]  d;
    } mem_t;

    resp_t      exp_q[$];
    mem_t       exp_mem[$];
    int         tests = 0;
    int         fails = 0;
    int         mem_count = 0;
    logic [7:0] fill_data = 8'h00;
    bit         mem_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [7:0] d);
        mem_t m;
        m.we = we; m.a = a; m.d = d;
        exp_mem.push_back(m);
    endtask

    // Response monitor: one pop per rising valid.
    initial begin
        logic  valid_d;
        resp_t e;
        valid_d = 1'b0;
        forever begin
            @(negedge clock);
            if (valid === 1'b1 && valid_d !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL resp_unexpected: got rdata %0h evict %0b expected no response", rdata, evict);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", rdata, e.rd);
                    check("resp_evict", evict, e.ev);
                end
            end
            valid_d = valid;
        end
    end

    // Backing memory: acks two cycles after seeing mem_req, checks the request against expectations.
    initial begin
        logic        cap_we;
        logic [31:0] cap_a;
        logic [7:0]  cap_d;
        mem_t        e;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (mem_req === 1'b1 && reset === 1'b0) begin
                cap_we = mem_we; cap_a = mem_addr; cap_d = mem_wdata;
                repeat (2) @(negedge clock);
                if (mem_req === 1'b1 && !mem_hold && reset === 1'b0) begin
                    check("mem_addr_stable", mem_addr, cap_a);
                    check("mem_we_stable", mem_we, cap_we);
                    if (exp_mem.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL mem_unexpected: got request addr %0h we %0b expected none", cap_a, cap_we);
                    end else begin
                        e = exp_mem.pop_front();
                        check("mem_we", cap_we, e.we);
                        check("mem_addr", cap_a, e.a);
                        if (e.we) check("mem_wdata", cap_d, e.d);
                    end
                    mem_rdata = fill_data;
                    mem_ack   = 1'b1;
                    mem_count++;
                end
            end
        end
    end

    task automatic txn(input logic [1:0] op, input logic [31:0] a, input logic [7:0] wd,
                       input logic [7:0] fd, input logic [7:0] exp_rd, input logic exp_ev,
                       input int exp_lat, input int nmem, input bit scramble, input int hold);
        int    lat;
        int    mem_before;
        resp_t r;
        r.rd = exp_rd; r.ev = exp_ev;
        exp_q.push_back(r);
        mem_before = mem_count;
        @(negedge clock);
        fill_data = fd;
        operation = op; addr = a; wdata = wd; request = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (scramble && lat == 1) begin
                operation = 2'b10; addr = 32'hDEAD_BEEF; wdata = 8'hEE;
            end
        end while (valid !== 1'b1 && lat < 200);
        if (valid !== 1'b1) begin
            tests++; fails++;
            $display("FAIL valid_timeout: got no valid after %0d cycles expected valid", lat);
        end
        if (exp_lat > 0) check("latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("valid_held", valid, 1'b1);
        end
        request = 1'b0;
        operation = NOP;
        @(negedge clock);
        check("valid_drop", valid, 1'b0);
        check("mem_txn_count", mem_count - mem_before, nmem);
        if (hold > 0) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                check("no_second_txn", valid, 1'b0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        reset = 1'b1; request = 1'b0; operation = NOP; addr = '0; wdata = '0;
        repeat (2) @(negedge clock);
        check("rst_valid", valid, 1'b0);
        check("rst_evict", evict, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        reset = 1'b0;

        // cold miss fill
        push_mem(1'b0, 32'h10, 8'h00);
        txn(RD, 32'h10, 8'h00, 8'hA5, 8'hA5, 1'b0, 0, 1, 1'b0, 0);
        // write hit, read hit
        txn(WR, 32'h10, 8'h3C, 8'h00, 8'h00, 1'b0, 2, 0, 1'b0, 0);
        txn(RD, 32'h10, 8'h00, 8'h00, 8'h3C, 1'b0, 2, 0, 1'b1, 0);
        // dirty conflict: writeback then fill
        push_mem(1'b1, 32'h10, 8'h3C);
        push_mem(1'b0, 32'h20, 8'h00);
        txn(RD, 32'h20, 8'h00, 8'h77, 8'h77, 1'b1, 0, 2, 1'b1, 0);
        // clean invalidate then refill
        txn(INV, 32'h20, 8'h00, 8'h00, 8'h00, 1'b0, 2, 0, 1'b0, 0);
        push_mem(1'b0, 32'h20, 8'h00);
        txn(RD, 32'h20, 8'h00, 8'h55, 8'h55, 1'b0, 0, 1, 1'b0, 0);
        // write miss to empty line, dirty invalidate, refill
        txn(WR, 32'h31, 8'h99, 8'h00, 8'h00, 1'b0, 2, 0, 1'b0, 0);
        push_mem(1'b1, 32'h31, 8'h99);
        txn(INV, 32'h31, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1, 1'b0, 0);
        push_mem(1'b0, 32'h31, 8'h00);
        txn(RD, 32'h31, 8'h00, 8'h12, 8'h12, 1'b0, 0, 1, 1'b0, 0);
        txn(NOP, 32'h31, 8'h00, 8'h00, 8'h00, 1'b0, 1, 0, 1'b0, 0);
        // write miss with dirty victim
        txn(WR, 32'h42, 8'hAA, 8'h00, 8'h00, 1'b0, 2, 0, 1'b0, 0);
        push_mem(1'b1, 32'h42, 8'hAA);
        txn(WR, 32'h52, 8'hBB, 8'h00, 8'h00, 1'b1, 0, 1, 1'b0, 0);
        txn(RD, 32'h52, 8'h00, 8'h00, 8'hBB, 1'b0, 2, 0, 1'b0, 0);
        // invalidate miss leaves the line alone
        txn(INV, 32'h62, 8'h00, 8'h00, 8'h00, 1'b0, 2, 0, 1'b0, 0);
        txn(RD, 32'h52, 8'h00, 8'h00, 8'hBB, 1'b0, 2, 0, 1'b0, 5);

        // reset in the middle of a fill
        mem_hold = 1'b1;
        @(negedge clock);
        operation = RD; addr = 32'h10; request = 1'b1;
        w = 0;
        while (mem_req !== 1'b1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("abort_fill_issued", mem_req, 1'b1);
        check("abort_fill_addr", mem_addr, 32'h10);
        #2 reset = 1'b1;
        #1;
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_valid", valid, 1'b0);
        @(negedge clock);
        request = 1'b0; operation = NOP;
        reset = 1'b0;
        mem_hold = 1'b0;
        push_mem(1'b0, 32'h10, 8'h00);
        txn(RD, 32'h10, 8'h00, 8'hC3, 8'hC3, 1'b0, 0, 1, 1'b0, 0);
        push_mem(1'b0, 32'h52, 8'h00);
        txn(RD, 32'h52, 8'h00, 8'h66, 8'h66, 1'b0, 0, 1, 1'b0, 0);

        repeat (4) @(negedge clock);
        check("resp_queue_drained", exp_q.size(), 0);
        check("mem_queue_drained", exp_mem.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
